// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional phase-accumulator baud tick generator with oversample divider
module uart_baud_gen #(
    parameter int ACC_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int INC_RESET  = 151
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] inc_in,
    input  logic                 inc_load,
    input  logic                 restart,
    output logic                 tick_os,
    output logic                 tick,
    output logic [ACC_WIDTH-1:0] inc_q
);

    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]      OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [ACC_WIDTH-1:0] HALF_PHASE = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] INC_INIT   = ACC_WIDTH'(INC_RESET);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 carry_q, carry_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [ACC_WIDTH-1:0] inc_d;
    logic [ACC_WIDTH:0]   sum;

    // Next-state: strobes re-phase and win over enable; otherwise accumulate or freeze
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d    = acc_q;
        carry_d  = 1'b0;
        os_cnt_d = os_cnt_q;
        inc_d    = inc_q;
        if (inc_load || restart) begin
            // A carry pending on this edge is dropped, so os_cnt stays cleared
            if (inc_load) begin
                inc_d = inc_in;
            end
            acc_d    = restart ? HALF_PHASE : '0;
            os_cnt_d = '0;
        end else begin
            // The pulse currently on tick_os is counted whether or not we keep running
            if (carry_q) begin
                os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
            end
            if (enable) begin
                acc_d   = sum[ACC_WIDTH-1:0];
                carry_d = sum[ACC_WIDTH];
            end
        end
    end

    // State registers; reset clears pulses immediately without a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            carry_q  <= 1'b0;
            os_cnt_q <= '0;
            inc_q    <= INC_INIT;
        end else begin
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            os_cnt_q <= os_cnt_d;
            inc_q    <= inc_d;
        end
    end

    assign tick_os = carry_q;
    assign tick    = carry_q && (os_cnt_q == OS_LAST);

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 16, meaning phase-accumulator width in bits (legal 4..24).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning tick_os pulses per tick (legal 2..64, any integer).
REQ-003 SHALL have parameter INC_RESET, default 151, meaning increment value loaded at reset (must be < 2^ACC_WIDTH).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port enable  input  1  meaning run the accumulator when high; freeze it when low.
REQ-007 SHALL have port inc_in  input  ACC_WIDTH  meaning new increment value.
REQ-008 SHALL have port inc_load  input  1  meaning a one-cycle strobe that captures inc_in.
REQ-009 SHALL have port restart  input  1  meaning a one-cycle strobe that re-phases the generator (Rx start-bit alignment).
REQ-010 SHALL have port tick_os  output  1  meaning a one-cycle oversample pulse.
REQ-011 SHALL have port tick  output  1  meaning a one-cycle bit-rate pulse, coincident with every OVERSAMPLE-th tick_os.
REQ-012 SHALL have port inc_q  output  ACC_WIDTH  meaning the increment currently in use.

Function
REQ-013 SHALL hold state in these registers: acc (ACC_WIDTH bits), carry_q (1 bit), os_cnt (clog2(OVERSAMPLE) bits) and inc_q.
REQ-014 SHALL, on each edge with enable=1 and no restart/inc_load, compute {c,s} = acc + inc_q (ACC_WIDTH+1 bits), then set acc<=s and carry_q<=c.
REQ-015 SHALL drive tick_os = carry_q (registered), so tick_os is high for exactly one cycle per accumulator wrap.
REQ-016 SHALL give average tick_os rate = f_clk*inc_q/2^ACC_WIDTH with no cumulative error; remainder stays in acc on wrap.
REQ-017 SHALL increment os_cnt on each edge where carry_q=1, wrapping from OVERSAMPLE-1 to 0.
REQ-018 SHALL drive tick = carry_q AND (os_cnt == OVERSAMPLE-1), combinational from registers only.
REQ-019 SHALL, with enable=0, hold acc and os_cnt and clear carry_q, so tick_os=tick=0 on the next cycle.
REQ-020 SHALL produce no pulses with inc_q=0; carry_q stays 0.
REQ-021 SHALL, on an inc_load edge, set inc_q<=inc_in and clear acc, carry_q and os_cnt; the new increment is first used on the next edge.
REQ-022 SHALL, on a restart edge, set acc to 2^(ACC_WIDTH-1) (half phase), clear carry_q, and clear os_cnt; inc_q is unchanged.
REQ-023 SHALL, when restart and inc_load occur together, apply both: inc_q<=inc_in, acc<=2^(ACC_WIDTH-1), carry_q<=0 and os_cnt<=0.
REQ-024 SHALL give restart and inc_load priority over enable; both take effect even when enable=0.
REQ-025 SHALL service a pending carry_q=1 on the edge where restart or inc_load arrives by clearing it; os_cnt is not advanced and no tick is issued.
REQ-026 SHALL never assert tick without tick_os in the same cycle.

Reset
REQ-027 SHALL, while rst=1, asynchronously force acc=0, carry_q=0, os_cnt=0 and inc_q=INC_RESET, so tick_os=0 and tick=0.
REQ-028 SHALL, after rst is released, perform the first accumulation on the first rising edge with enable=1.
REQ-029 SHALL, on reset asserted mid-operation, remove any in-flight pulse immediately without waiting for a clock edge.

Verification
REQ-030 SHALL check basic rate: ACC_WIDTH=4, OVERSAMPLE=4, load inc=4, enable=1 -> tick_os every 4th cycle, tick every 16th cycle, each 1 cycle wide.
REQ-031 SHALL check fractional rate: ACC_WIDTH=4, inc=3 -> exactly 3 tick_os pulses in any 16-cycle window, with gaps of 5,5,6 cycles in repeating order.
REQ-032 SHALL check enable gating: deassert enable for 7 cycles mid-count -> no pulses during the gap; afterwards pulse phase is delayed by exactly 7 cycles and os_cnt continuity is preserved.
REQ-033 SHALL check restart: ACC_WIDTH=4, inc=4, restart pulse -> first tick_os 2 cycles after the restart edge, tick after 4 tick_os; a restart coinciding with carry_q=1 issues no tick.
REQ-034 SHALL check reload: change inc 4->8 via inc_load -> inc_q=8 next cycle, acc=0, next tick_os 2 cycles after the edge following the load.
REQ-035 SHALL check reset: assert rst asynchronously while tick_os=1 -> tick_os and tick drop before the next edge; after release, inc_q=INC_RESET.
